// File: rtl/rk_pkg.sv
// Shared definitions for the rk keyboard-side PPI: register map,
// control word bit positions and the reset control word.
package rk_pkg;

  typedef enum logic [1:0] {
    PPI_PA = 2'd0,
    PPI_PB = 2'd1,
    PPI_PC = 2'd2,
    PPI_CW = 2'd3
  } ppi_addr_e;

  localparam int unsigned CW_MODESET = 7;
  localparam int unsigned CW_PA_IN   = 4;
  localparam int unsigned CW_PCH_IN  = 3;
  localparam int unsigned CW_PB_IN   = 1;
  localparam int unsigned CW_PCL_IN  = 0;

  localparam logic [7:0] RESET_CW = 8'h9B;

  // Only mode 0 is supported, so the mode-select bits are forced to zero.
  function automatic logic [7:0] cw_mode0(input logic [7:0] d);
    return {1'b1, 2'b00, d[4:3], 1'b0, d[1:0]};
  endfunction

endpackage

// File: rtl/rk_ppi.sv
// Mode-0 subset of an 8255 PPI: control word, output latches, bit set/reset
// on port C and a rising-edge write detector on the CPU write level.
module rk_ppi #(
  parameter logic [7:0] RESET_CW = rk_pkg::RESET_CW
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] addr,
  input  logic       we,
  input  logic [7:0] idata,
  output logic [7:0] odata,
  input  logic [7:0] pa_i,
  input  logic [7:0] pb_i,
  input  logic [7:0] pc_i,
  output logic [7:0] pa_o,
  output logic [7:0] pb_o,
  output logic [7:0] pc_o,
  output logic       pa_oe,
  output logic       pb_oe,
  output logic [7:0] pc_oe
);
  import rk_pkg::*;

  logic [7:0] r_cw;
  logic [7:0] r_la;
  logic [7:0] r_lb;
  logic [7:0] r_lc;
  logic       r_we_d;

  logic       w_wr_stb;
  logic       w_pa_oe;
  logic       w_pb_oe;
  logic [7:0] w_pc_oe;

  assign w_wr_stb = we & ~r_we_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cw   <= RESET_CW;
      r_la   <= '0;
      r_lb   <= '0;
      r_lc   <= '0;
      r_we_d <= 1'b0;
    end else begin
      r_we_d <= we;
      if (w_wr_stb) begin
        unique case (ppi_addr_e'(addr))
          PPI_PA: r_la <= idata;
          PPI_PB: r_lb <= idata;
          PPI_PC: r_lc <= idata;
          PPI_CW: begin
            if (idata[CW_MODESET]) begin
              r_cw <= cw_mode0(idata);
              r_la <= '0;
              r_lb <= '0;
              r_lc <= '0;
            end else begin
              r_lc[idata[3:1]] <= idata[0];
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_pa_oe      = ~r_cw[CW_PA_IN];
    w_pb_oe      = ~r_cw[CW_PB_IN];
    w_pc_oe[7:4] = {4{~r_cw[CW_PCH_IN]}};
    w_pc_oe[3:0] = {4{~r_cw[CW_PCL_IN]}};
  end

  always_comb begin
    odata = '1;
    unique case (ppi_addr_e'(addr))
      PPI_PA:  odata = w_pa_oe ? r_la : pa_i;
      PPI_PB:  odata = w_pb_oe ? r_lb : pb_i;
      PPI_PC:  odata = (r_lc & w_pc_oe) | (pc_i & ~w_pc_oe);
      PPI_CW:  odata = '1;
      default: odata = '1;
    endcase
  end

  assign pa_o  = r_la;
  assign pb_o  = r_lb;
  assign pc_o  = r_lc;
  assign pa_oe = w_pa_oe;
  assign pb_oe = w_pb_oe;
  assign pc_oe = w_pc_oe;

endmodule

// File: tb/tb_rk_ppi.sv
// Directed and randomized bench for rk_ppi against a register-level model.
module tb_rk_ppi;

  logic       clk;
  logic       reset;
  logic [1:0] addr;
  logic       we;
  logic [7:0] idata;
  logic [7:0] odata;
  logic [7:0] pa_i, pb_i, pc_i;
  logic [7:0] pa_o, pb_o, pc_o;
  logic       pa_oe, pb_oe;
  logic [7:0] pc_oe;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // reference state
  logic [7:0] m_cw, m_la, m_lb, m_lc;

  rk_ppi #(.RESET_CW(8'h9B)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .idata (idata),
    .odata (odata),
    .pa_i  (pa_i),
    .pb_i  (pb_i),
    .pc_i  (pc_i),
    .pa_o  (pa_o),
    .pb_o  (pb_o),
    .pc_o  (pc_o),
    .pa_oe (pa_oe),
    .pb_oe (pb_oe),
    .pc_oe (pc_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_cw = 8'h9B;
    m_la = 8'h00;
    m_lb = 8'h00;
    m_lc = 8'h00;
  endfunction

  function automatic void m_write(input logic [1:0] a, input logic [7:0] d);
    if (a == 2'd0) m_la = d;
    else if (a == 2'd1) m_lb = d;
    else if (a == 2'd2) m_lc = d;
    else if (d[7]) begin
      m_cw = {1'b1, 2'b00, d[4], d[3], 1'b0, d[1], d[0]};
      m_la = 0;
      m_lb = 0;
      m_lc = 0;
    end else begin
      m_lc[d[3:1]] = d[0];
    end
  endfunction

  function automatic logic [7:0] m_read(input logic [1:0] a);
    if (a == 2'd0) return m_cw[4] ? pa_i : m_la;
    if (a == 2'd1) return m_cw[1] ? pb_i : m_lb;
    if (a == 2'd2) return {m_cw[3] ? pc_i[7:4] : m_lc[7:4], m_cw[0] ? pc_i[3:0] : m_lc[3:0]};
    return 8'hFF;
  endfunction

  function automatic logic [7:0] m_pc_oe();
    return {m_cw[3] ? 4'h0 : 4'hF, m_cw[0] ? 4'h0 : 4'hF};
  endfunction

  // Compare every observable output against the model (called at a negedge, we low).
  task automatic check_all(input string tag);
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1;
      check($sformatf("%s.odata%0d", tag, a), odata, m_read(2'(a)));
    end
    check({tag, ".pa_o"}, pa_o, m_la);
    check({tag, ".pb_o"}, pb_o, m_lb);
    check({tag, ".pc_o"}, pc_o, m_lc);
    check({tag, ".pa_oe"}, {7'd0, pa_oe}, {7'd0, ~m_cw[4]});
    check({tag, ".pb_oe"}, {7'd0, pb_oe}, {7'd0, ~m_cw[1]});
    check({tag, ".pc_oe"}, pc_oe, m_pc_oe());
  endtask

  // Raise we for 'hold' cycles; after the commit edge addr/idata are scrambled.
  task automatic wr(input logic [1:0] a, input logic [7:0] d, input int unsigned hold);
    @(negedge clk);
    addr  = a;
    idata = d;
    we    = 1'b1;
    #1;
    check("precommit_read", odata, m_read(a));
    @(posedge clk);
    m_write(a, d);
    for (int unsigned h = 1; h < hold; h++) begin
      @(negedge clk);
      idata = 8'($urandom);
      addr  = 2'($urandom);
    end
    @(negedge clk);
    we = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    we    = 1'b0;
    addr  = 2'd0;
    idata = 8'h00;
    pa_i  = 8'h5A;
    pb_i  = 8'h00;
    pc_i  = 8'h00;
    m_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // reset state
    addr = 2'd3; #1;
    check("rst_cw_read", odata, 8'hFF);
    addr = 2'd0; #1;
    check("rst_pa_follows_pin", odata, 8'h5A);
    check_all("rst");

    // CW 82, PA write
    wr(2'd3, 8'h82, 1);
    pb_i = 8'hF7;
    wr(2'd0, 8'hFE, 1);
    check("t2_pa_oe", {7'd0, pa_oe}, 8'h01);
    check("t2_pa_o", pa_o, 8'hFE);
    check("t2_pc_oe", pc_oe, 8'hFF);
    addr = 2'd1; #1;
    check("t2_pb_pin", odata, 8'hF7);
    check_all("t2");

    // mode set clears latches
    wr(2'd0, 8'h3C, 1);
    check("t3_pa_before", pa_o, 8'h3C);
    wr(2'd3, 8'h80, 1);
    check("t3_pa_cleared", pa_o, 8'h00);
    check_all("t3");

    // bit set/reset on PC7
    wr(2'd2, 8'h15, 1);
    wr(2'd3, 8'h0F, 1);
    check("t4_bsr_set", pc_o, 8'h95);
    wr(2'd3, 8'h0E, 1);
    check("t4_bsr_clr", pc_o, 8'h15);
    check_all("t4");

    // held write commits once
    @(negedge clk);
    addr = 2'd0; idata = 8'h11; we = 1'b1;
    @(posedge clk);
    m_write(2'd0, 8'h11);
    @(negedge clk);
    idata = 8'h22;
    repeat (4) @(negedge clk);
    we = 1'b0;
    check("t5_held", pa_o, 8'h11);
    wr(2'd0, 8'h22, 1);
    check("t5_second", pa_o, 8'h22);

    // PC split direction
    wr(2'd3, 8'h8A, 1);
    wr(2'd2, 8'h0F, 1);
    pc_i = 8'hA5;
    addr = 2'd2; #1;
    check("t6_pc_read", odata, 8'hAF);
    check("t6_pc_oe", pc_oe, 8'h0F);
    check_all("t6");

    // reset released with we still high commits on first edge
    @(negedge clk);
    addr = 2'd1; idata = 8'h77; we = 1'b1; reset = 1'b1;
    m_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    m_write(2'd1, 8'h77);
    @(negedge clk);
    we = 1'b0;
    check("rst_midwrite_pb", pb_o, 8'h77);
    check_all("rstwr");

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      logic [1:0] ra;
      logic [7:0] rd;
      ra = 2'($urandom);
      rd = 8'($urandom);
      if (ra == 2'd3 && ($urandom_range(0, 3) == 0)) rd[7] = 1'b1;
      pa_i = 8'($urandom);
      pb_i = 8'($urandom);
      pc_i = 8'($urandom);
      wr(ra, rd, $urandom_range(1, 3));
      check_all("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
